fixed_point_resizer: RTL and testbench
======================================

FIXED_POINT_RESIZER -- requirements
Module: fixed_point_resizer

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 16: input sample width in bits, signed two's complement.
REQ-002 SHALL have parameter DIN_FRAC, default 8: input fractional bits, 0..DIN_WIDTH-1.
REQ-003 SHALL have parameter DOUT_WIDTH, default 8: output sample width in bits, signed two's complement.
REQ-004 SHALL have parameter DOUT_FRAC, default 4: output fractional bits, 0..DOUT_WIDTH-1.
REQ-005 SHALL have parameter CHANNELS, default 1: parallel lanes sharing one handshake, 1..16.
REQ-006 SHALL have ports as follows; the design uses one clock, and reset is synchronous and active-low:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- din  in  CHANNELS*DIN_WIDTH  samples, lane 0 in the LSBs.
- round_mode  in  2  rounding mode: 00 truncate (floor), 01 round-half-up, 10 round-half-even, 11 reserved and treated as 00.
- sat_en  in  1  overflow handling: 1 saturate, 0 wrap.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- dout  out  CHANNELS*DOUT_WIDTH  converted samples.
- ovr  out  CHANNELS  per-lane overflow flag for the current output beat.
- ovr_sticky  out  1  set by any overflow since reset or clear.
- ovr_clear  in  1  synchronous clear of ovr_sticky and ovr_count.
- ovr_count  out  16  number of output beats with at least one lane overflowing.

Function
REQ-007 SHALL accept an input beat on a rising edge when in_valid=1 and in_ready=1.
REQ-008 SHALL sample round_mode and sat_en together with din, and carry them through the pipeline with that beat.
REQ-009 SHALL be a 2-stage pipeline:
- stage 1: align and round.
- stage 2: range check, saturate or wrap, and register the outputs.
- latency: exactly 2 cycles from acceptance to out_valid while out_ready=1.
REQ-010 SHALL stall both stages, with no data change, while out_valid=1 and out_ready=0.
REQ-011 SHALL drive in_ready = !(out_valid && !out_ready), a combinational path that is permitted, so back-to-back beats sustain 1 beat/cycle.
REQ-012 SHALL let a stage advance into an empty next stage, so bubbles collapse.
REQ-013 SHALL hold dout and ovr stable while out_valid=1 and out_ready=0.
REQ-014 SHALL compute, per lane, s = DOUT_FRAC - DIN_FRAC:
- if s>=0: left-shift by s exactly, with no rounding.
- if s<0: drop k=-s LSBs according to the rounding mode.
REQ-015 SHALL apply the rounding modes as follows:
- truncate: arithmetic right shift, i.e. floor.
- half-up: add 2^(k-1), then arithmetic shift.
- half-even: on an exact tie (dropped bits = 1 followed by zeros) round to the even result; otherwise round to nearest.
REQ-016 SHALL carry an intermediate width of DIN_WIDTH+max(s,0)+1 bits, so rounding carry never wraps internally.
REQ-017 SHALL set ovr[lane] when the rounded value lies outside [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
REQ-018 SHALL handle an overflowing lane as follows:
- sat_en=1: clamp to 0x7F..F for positive overflow, 0x80..0 for negative overflow.
- sat_en=0: output the DOUT_WIDTH LSBs (wrap).
REQ-019 SHALL detect an overflow caused by round-up carry (e.g. 127.5 -> 128) under REQ-017.
REQ-020 SHALL set ovr_sticky on the clock edge where an output beat with any ovr bit set is transferred (out_valid && out_ready).
REQ-021 SHALL increment ovr_count by 1 on each such transfer, saturating at 0xFFFF.
REQ-022 SHALL, when ovr_clear=1, zero ovr_sticky and ovr_count on the next edge; clear has priority over a simultaneous increment, and that event is lost.
REQ-023 SHALL accept values of round_mode=11 as truncate, with no error flag.

Reset
REQ-024 SHALL, when rst_n=0 at a rising edge, set out_valid=0, dout=0, ovr=0, ovr_sticky=0, ovr_count=0, and empty both stages.
REQ-025 SHALL discard in-flight beats on reset mid-operation; no stale beat appears after rst_n rises.
REQ-026 SHALL hold in_ready=1 during and after reset, since out_valid=0.

Verification
REQ-027 Ties, defaults, lane 0, out_ready=1: din 0x0188 (24.5 LSB) -> dout 0x18 truncate, 0x19 half-up, 0x18 half-even, ovr=0, out_valid 2 cycles after acceptance.
REQ-028 Negative tie: din 0xFF78 (-8.5 LSB) -> dout 0xF7 truncate, 0xF8 half-up, 0xF8 half-even.
REQ-029 Overflow: din 0x7F00 -> sat_en=1 gives 0x7F and sat_en=0 gives 0xF0; din 0x8000 with sat_en=1 gives 0x80; ovr=1 and ovr_count increments once per beat.
REQ-030 Round carry: din 0x07F8, half-up, sat_en=1 -> dout 0x7F, ovr=1; truncate -> 0x7F, ovr=0.
REQ-031 Backpressure: stream 8 beats with out_ready toggled randomly -> all 8 outputs in order, none duplicated, dout stable while stalled, in_ready low only during stall.
REQ-032 Counter/reset: ovr_clear coincident with an overflow transfer -> ovr_count=0; rst_n=0 with 2 beats in flight -> no out_valid after release until new input.

Source files
------------

// File: rtl/fixed_point_resizer.sv
// Converts signed fixed-point samples between Q formats across CHANNELS lanes,
// with selectable rounding, saturate/wrap overflow handling and overflow statistics.
module fixed_point_resizer #(
    parameter int DIN_WIDTH  = 16,
    parameter int DIN_FRAC   = 8,
    parameter int DOUT_WIDTH = 8,
    parameter int DOUT_FRAC  = 4,
    parameter int CHANNELS   = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CHANNELS*DIN_WIDTH-1:0]    din,
    input  logic [1:0]                       round_mode,
    input  logic                             sat_en,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CHANNELS*DOUT_WIDTH-1:0]   dout,
    output logic [CHANNELS-1:0]              ovr,
    output logic                             ovr_sticky,
    input  logic                             ovr_clear,
    output logic [15:0]                      ovr_count
);

    localparam int SHIFT = DOUT_FRAC - DIN_FRAC;
    localparam int LS    = (SHIFT > 0) ? SHIFT : 0;
    localparam int K     = (SHIFT < 0) ? -SHIFT : 0;
    localparam int KM1   = (K > 0) ? K - 1 : 0;
    localparam int IW    = DIN_WIDTH + LS + 1;
    localparam int CW    = ((IW > DOUT_WIDTH) ? IW : DOUT_WIDTH) + 1;

    localparam logic signed [IW-1:0] HALF      = (K > 0) ? (IW'(1) <<< KM1) : '0;
    localparam logic signed [IW-1:0] DROP_MASK = (IW'(1) <<< K) - IW'(1);
    localparam logic signed [CW-1:0] MAX_V = {{(CW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] MIN_V = {{(CW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
    localparam logic [DOUT_WIDTH-1:0] SAT_POS = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [DOUT_WIDTH-1:0] SAT_NEG = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    function automatic logic signed [IW-1:0] align_round(
        input logic signed [DIN_WIDTH-1:0] x,
        input logic [1:0]                  mode
    );
        logic signed [IW-1:0] ext;
        logic signed [IW-1:0] flr;
        logic signed [IW-1:0] dropped;
        logic signed [IW-1:0] res;
        ext     = IW'(x);
        flr     = ext >>> K;
        dropped = ext & DROP_MASK;
        if (SHIFT >= 0) begin
            res = ext <<< LS;
        end else begin
            case (mode)
                2'b01:   res = (ext + HALF) >>> K;
                2'b10: begin
                    // Exact tie: bump only when the floor is odd, landing on even.
                    if (dropped > HALF)
                        res = flr + IW'(1);
                    else if (dropped == HALF)
                        res = flr + $signed({{(IW-1){1'b0}}, flr[0]});
                    else
                        res = flr;
                end
                default: res = flr;
            endcase
        end
        return res;
    endfunction

    logic                   r_s1_valid;
    logic                   r_s1_sat_en;
    logic signed [IW-1:0]   r_s1_val [CHANNELS];
    logic signed [IW-1:0]   w_s1_next [CHANNELS];

    logic                              r_out_valid;
    logic [CHANNELS*DOUT_WIDTH-1:0]    r_dout;
    logic [CHANNELS-1:0]               r_ovr;
    logic [CHANNELS*DOUT_WIDTH-1:0]    w_dout_next;
    logic [CHANNELS-1:0]               w_ovr_next;

    logic        r_ovr_sticky;
    logic [15:0] r_ovr_count;
    logic        w_stall;
    logic        w_xfer;

    assign w_stall    = r_out_valid && !out_ready;
    assign w_xfer     = r_out_valid && out_ready;
    assign in_ready   = !w_stall;
    assign out_valid  = r_out_valid;
    assign dout       = r_dout;
    assign ovr        = r_ovr;
    assign ovr_sticky = r_ovr_sticky;
    assign ovr_count  = r_ovr_count;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_s1_next = '{default: '0};
        for (int i = 0; i < CHANNELS; i++)
            w_s1_next[i] = align_round(din[i*DIN_WIDTH +: DIN_WIDTH], round_mode);
    end

    always_comb begin
        logic signed [CW-1:0] v;
        w_dout_next = '0;
        w_ovr_next  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            v = CW'(r_s1_val[i]);
            w_ovr_next[i] = (v > MAX_V) || (v < MIN_V);
            if (w_ovr_next[i] && r_s1_sat_en)
                w_dout_next[i*DOUT_WIDTH +: DOUT_WIDTH] = v[CW-1] ? SAT_NEG : SAT_POS;
            else
                w_dout_next[i*DOUT_WIDTH +: DOUT_WIDTH] = v[DOUT_WIDTH-1:0];
        end
    end

    // NOTE: stage-1 payload has no reset; r_s1_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (!w_stall && in_valid) begin
            r_s1_val    <= w_s1_next;
            r_s1_sat_en <= sat_en;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_ovr       <= '0;
        end else if (!w_stall) begin
            r_s1_valid  <= in_valid;
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_dout <= w_dout_next;
                r_ovr  <= w_ovr_next;
            end
        end
    end

    // Clear wins over a coincident overflow transfer; that event is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovr_sticky <= 1'b0;
            r_ovr_count  <= '0;
        end else if (ovr_clear) begin
            r_ovr_sticky <= 1'b0;
            r_ovr_count  <= '0;
        end else if (w_xfer && (|r_ovr)) begin
            r_ovr_sticky <= 1'b1;
            if (r_ovr_count != 16'hFFFF)
                r_ovr_count <= r_ovr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fixed_point_resizer.sv
// Directed bench for fixed_point_resizer: two lanes, Q8.8 -> Q4.4, with
// hand-computed expectations for rounding, overflow, counters, backpressure and reset.
module tb_fixed_point_resizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] din;
    logic [1:0]  round_mode;
    logic        sat_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic [1:0]  ovr;
    logic        ovr_sticky;
    logic        ovr_clear;
    logic [15:0] ovr_count;

    int n_checks = 0;
    int n_fail   = 0;

    fixed_point_resizer #(
        .DIN_WIDTH (16),
        .DIN_FRAC  (8),
        .DOUT_WIDTH(8),
        .DOUT_FRAC (4),
        .CHANNELS  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .round_mode(round_mode),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .ovr       (ovr),
        .ovr_sticky(ovr_sticky),
        .ovr_clear (ovr_clear),
        .ovr_count (ovr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated beat with out_ready=1: latency, payload, then counters after transfer.
    task automatic run_vec(input string tag, input logic [31:0] d, input logic [1:0] rm,
                           input logic s, input logic [15:0] exp_d, input logic [1:0] exp_o,
                           input logic [15:0] exp_cnt, input logic exp_stk);
        @(negedge clk);
        din = d; round_mode = rm; sat_en = s; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; round_mode = ~rm; sat_en = ~s; din = ~d;
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_dout"}, 64'(dout), 64'(exp_d));
        check({tag, "_ovr"}, 64'(ovr), 64'(exp_o));
        @(negedge clk);
        check({tag, "_drain"}, 64'(out_valid), 64'd0);
        check({tag, "_cnt"}, 64'(ovr_count), 64'(exp_cnt));
        check({tag, "_stk"}, 64'(ovr_sticky), 64'(exp_stk));
    endtask

    initial begin
        logic [15:0] prev_dout;
        logic        prev_stall;
        int          sent;
        int          got;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovr_clear = 1'b0;
        din = '0; round_mode = 2'b00; sat_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_ovr", 64'(ovr), 64'd0);
        check("rst_stk", 64'(ovr_sticky), 64'd0);
        check("rst_cnt", 64'(ovr_count), 64'd0);

        // Ties: lane0 24.5 LSB, lane1 2.5 LSB; mode 11 behaves as truncate.
        run_vec("tie_trunc", {16'h0028, 16'h0188}, 2'b00, 1'b1, 16'h0218, 2'b00, 16'd0, 1'b0);
        run_vec("tie_up",    {16'h0028, 16'h0188}, 2'b01, 1'b1, 16'h0319, 2'b00, 16'd0, 1'b0);
        run_vec("tie_even",  {16'h0028, 16'h0188}, 2'b10, 1'b1, 16'h0218, 2'b00, 16'd0, 1'b0);
        run_vec("tie_rsvd",  {16'h0028, 16'h0188}, 2'b11, 1'b1, 16'h0218, 2'b00, 16'd0, 1'b0);
        // Negative tie -8.5 on lane0, odd tie 3.5 on lane1.
        run_vec("neg_trunc", {16'h0038, 16'hFF78}, 2'b00, 1'b1, 16'h03F7, 2'b00, 16'd0, 1'b0);
        run_vec("neg_up",    {16'h0038, 16'hFF78}, 2'b01, 1'b1, 16'h04F8, 2'b00, 16'd0, 1'b0);
        run_vec("neg_even",  {16'h0038, 16'hFF78}, 2'b10, 1'b1, 16'h04F8, 2'b00, 16'd0, 1'b0);
        // Overflow: saturate, wrap, negative clamp, both lanes in one beat.
        run_vec("ovf_sat",   {16'h0100, 16'h7F00}, 2'b00, 1'b1, 16'h107F, 2'b01, 16'd1, 1'b1);
        run_vec("ovf_wrap",  {16'h0100, 16'h7F00}, 2'b00, 1'b0, 16'h10F0, 2'b01, 16'd2, 1'b1);
        run_vec("ovf_both",  {16'h7F00, 16'h8000}, 2'b00, 1'b1, 16'h7F80, 2'b11, 16'd3, 1'b1);
        // Round-up carry: 127.5 -> 128 overflows; lane1 -127.5 -> -127.
        run_vec("carry_up",  {16'hF808, 16'h07F8}, 2'b01, 1'b1, 16'h817F, 2'b01, 16'd4, 1'b1);
        run_vec("carry_tr",  {16'hF808, 16'h07F8}, 2'b00, 1'b1, 16'h807F, 2'b00, 16'd4, 1'b1);
        run_vec("neg_wrap",  {16'h8000, 16'h0000}, 2'b00, 1'b0, 16'h0000, 2'b10, 16'd5, 1'b1);

        // Clear coincident with an overflow transfer: the increment is lost.
        @(negedge clk);
        din = {16'h0000, 16'h7F00}; round_mode = 2'b00; sat_en = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("clr_valid", 64'(out_valid), 64'd1);
        check("clr_ovr", 64'(ovr), 64'd1);
        ovr_clear = 1'b1;
        @(negedge clk);
        ovr_clear = 1'b0;
        check("clr_cnt", 64'(ovr_count), 64'd0);
        check("clr_stk", 64'(ovr_sticky), 64'd0);
        run_vec("post_clr", {16'h0000, 16'h7F00}, 2'b00, 1'b1, 16'h007F, 2'b01, 16'd1, 1'b1);

        // Backpressure: 8 beats, random out_ready, in-order delivery and stable stalls.
        sent = 0; got = 0; prev_stall = 1'b0; prev_dout = '0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready  = 1'($urandom_range(0, 1));
            in_valid   = (sent < 8);
            din        = {16'((sent + 1) << 4), 16'(sent << 8)};
            round_mode = 2'b00;
            sat_en     = 1'b1;
            #1;
            if (prev_stall) begin
                check("bp_hold_valid", 64'(out_valid), 64'd1);
                check("bp_hold_dout", 64'(dout), 64'(prev_dout));
            end
            check("bp_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                check($sformatf("bp_dout%0d", got), 64'(dout), 64'({8'(got + 1), 8'(got * 16)}));
                check($sformatf("bp_ovr%0d", got), 64'(ovr), 64'd0);
                got++;
            end
            if (in_valid && in_ready)
                sent++;
            prev_stall = out_valid && !out_ready;
            prev_dout  = dout;
        end
        check("bp_beats", 64'(got), 64'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_cnt", 64'(ovr_count), 64'd1);

        // Reset with two beats in flight: nothing stale emerges afterwards.
        @(negedge clk);
        din = {16'h0000, 16'h7F00}; in_valid = 1'b1;
        @(negedge clk);
        din = {16'h0100, 16'h0100};
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("rf_in_ready", 64'(in_ready), 64'd1);
        check("rf_valid", 64'(out_valid), 64'd0);
        check("rf_dout", 64'(dout), 64'd0);
        check("rf_cnt", 64'(ovr_count), 64'd0);
        check("rf_stk", 64'(ovr_sticky), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rf_flush%0d", i), 64'(out_valid), 64'd0);
        end
        run_vec("after_rst", {16'h0028, 16'h0188}, 2'b01, 1'b1, 16'h0319, 2'b00, 16'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
